// File: rtl/filter_sample_sequencer_if.sv
// Result stream from the sample sequencer: captured filter output with
// a valid/ready handshake.
interface filter_sample_sequencer_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/filter_sample_sequencer.sv
// Rate-paced sample player for the filter datapath: reads a sample memory,
// strobes each sample into the filter and captures the delayed result.
module filter_sample_sequencer #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 100,
  parameter int ADDR_W   = 7,
  parameter int DIV_W    = 16,
  parameter int FILT_LAT = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       single_shot,
  input  logic [DIV_W-1:0]           rate_div,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [DATA_W-1:0]          mem_data,
  output logic [DATA_W-1:0]          filt_in,
  output logic                       filt_en,
  input  logic [DATA_W-1:0]          filt_out,
  filter_sample_sequencer_if.master  result,
  output logic                       busy,
  output logic                       overrun
);

  typedef enum logic [1:0] {IDLE, READ, LOAD, HOLD} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state;
  logic [DIV_W-1:0]    divider;
  logic                stop_pending;
  logic                oneshot;
  logic [FILT_LAT-1:0] lat_pipe;
  logic                tap;

  assign tap = lat_pipe[FILT_LAT-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      mem_addr         <= '0;
      filt_in          <= '0;
      filt_en          <= 1'b0;
      result.out_data  <= '0;
      result.out_valid <= 1'b0;
      busy             <= 1'b0;
      overrun          <= 1'b0;
      divider          <= '0;
      stop_pending     <= 1'b0;
      oneshot          <= 1'b0;
      lat_pipe         <= '0;
    end else begin
      filt_en <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            mem_addr     <= '0;
            divider      <= '0;
            oneshot      <= single_shot;
            overrun      <= 1'b0;
            stop_pending <= 1'b0;
            busy         <= 1'b1;
            state        <= READ;
          end
        end
        READ: begin
          divider <= divider + 1'b1;
          state   <= LOAD;
        end
        LOAD: begin
          filt_in <= mem_data;
          filt_en <= 1'b1;
          divider <= divider + 1'b1;
          state   <= HOLD;
        end
        HOLD: begin
          // divider is already >= 2 here, so this also enforces the minimum period
          if (divider >= rate_div) begin
            if (stop_pending || (oneshot && mem_addr == LAST_ADDR)) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              mem_addr <= (mem_addr == LAST_ADDR) ? '0 : mem_addr + 1'b1;
              divider  <= '0;
              state    <= READ;
            end
          end else begin
            divider <= divider + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (stop && state != IDLE) stop_pending <= 1'b1;

      lat_pipe[0] <= filt_en;
      for (int unsigned i = 1; i < FILT_LAT; i++) lat_pipe[i] <= lat_pipe[i-1];

      // Capture after the start-time overrun clear so a capture in that cycle still flags
      if (tap) begin
        result.out_data  <= filt_out;
        result.out_valid <= 1'b1;
        if (result.out_valid && !result.out_ready) overrun <= 1'b1;
      end else if (result.out_valid && result.out_ready) begin
        result.out_valid <= 1'b0;
      end
    end
  end

endmodule
